// File: rtl/daq_params_pkg.sv
// Shared DAQ datapath parameters and the DAC burst controller state type.
// Holds sample/batch/counter widths and the maximum shift amount.
package daq_params_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int BATCH_SIZE       = 16;
  localparam int BS_WIDTH         = 16;
  localparam int MAX_SCALE_FACTOR = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } dac_burst_state_t;

endpackage

// File: rtl/batch_scaler.sv
// Combinational per-lane arithmetic right shift of a packed sample batch.
// Ports: in_batch, shift (0..15) -> out_batch, same width as in_batch.
module batch_scaler #(
  parameter int SAMPLE_WIDTH = daq_params_pkg::SAMPLE_WIDTH,
  parameter int BATCH_SIZE   = daq_params_pkg::BATCH_SIZE
) (
  input  logic [SAMPLE_WIDTH*BATCH_SIZE-1:0] in_batch,
  input  logic [3:0]                         shift,
  output logic [SAMPLE_WIDTH*BATCH_SIZE-1:0] out_batch
);

  for (genvar i = 0; i < BATCH_SIZE; i++) begin : g_lane
    assign out_batch[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
      $signed(in_batch[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) >>> shift;
  end

endmodule

// File: rtl/dac_burst_ctrl.sv
// DAC burst controller: one registered stage scaling upstream batches
// into the DAC stream for a counted or continuous burst.
// Ports: clk, rst_n, start, halt, burst_size, scale_factor,
//   s_batch/s_valid/s_ready (in), m_batch/m_valid/m_ready (out),
//   busy, done, sent_count; underrun_count when DAC_BURST_UNDERRUN_EN.
// DAC_BURST_UNDERRUN_EN: emit zero batches when upstream runs dry.
module dac_burst_ctrl #(
  parameter int SAMPLE_WIDTH = daq_params_pkg::SAMPLE_WIDTH,
  parameter int BATCH_SIZE   = daq_params_pkg::BATCH_SIZE,
  parameter int BS_WIDTH     = daq_params_pkg::BS_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               halt,
  input  logic [BS_WIDTH-1:0]                burst_size,
  input  logic [3:0]                         scale_factor,
  input  logic [SAMPLE_WIDTH*BATCH_SIZE-1:0] s_batch,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [SAMPLE_WIDTH*BATCH_SIZE-1:0] m_batch,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               busy,
  output logic                               done,
  output logic [BS_WIDTH-1:0]                sent_count
`ifdef DAC_BURST_UNDERRUN_EN
  ,
  output logic [BS_WIDTH-1:0]                underrun_count
`endif
);

  import daq_params_pkg::*;

  localparam int W = SAMPLE_WIDTH * BATCH_SIZE;

  dac_burst_state_t  state_q, state_d;
  logic [BS_WIDTH-1:0] size_q, size_d;
  logic [3:0]        scale_q, scale_d;
  logic [BS_WIDTH-1:0] issued_q, issued_d;
  logic [BS_WIDTH-1:0] sent_q, sent_d;
  logic              m_valid_q, m_valid_d;
  logic [W-1:0]      m_batch_q, m_batch_d;
  logic              done_q, done_d;
`ifdef DAC_BURST_UNDERRUN_EN
  logic [BS_WIDTH-1:0] under_q, under_d;
`endif

  logic         run;
  logic         slot_free;
  logic         room;
  logic         s_fire;
  logic         m_fire;
  logic         u_fire;
  logic [W-1:0] scaled;

  batch_scaler #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .BATCH_SIZE   (BATCH_SIZE)
  ) u_scaler (
    .in_batch  (s_batch),
    .shift     (scale_q),
    .out_batch (scaled)
  );

  assign run       = (state_q == ST_RUN);
  assign slot_free = !m_valid_q || m_ready;
  // issued counts batches loaded into the slot, so a counted
  // burst never over-fetches even while the output stalls
  assign room      = (size_q == '0) || (issued_q < size_q);
  assign s_ready   = run && slot_free && room;
  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid_q && m_ready;
`ifdef DAC_BURST_UNDERRUN_EN
  assign u_fire    = run && slot_free && room && !s_valid;
`else
  assign u_fire    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    scale_d   = scale_q;
    issued_d  = issued_q;
    sent_d    = sent_q;
    m_valid_d = m_valid_q;
    m_batch_d = m_batch_q;
    done_d    = 1'b0;
`ifdef DAC_BURST_UNDERRUN_EN
    under_d   = under_q;
`endif
    if (m_fire) begin
      m_valid_d = 1'b0;
      if (sent_q != '1) sent_d = sent_q + 1'b1;
    end
    if (s_fire || u_fire) begin
      m_valid_d = 1'b1;
      m_batch_d = s_fire ? scaled : '0;
      if (issued_q != '1) issued_d = issued_q + 1'b1;
    end
`ifdef DAC_BURST_UNDERRUN_EN
    if (u_fire && under_q != '1) under_d = under_q + 1'b1;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !halt) begin
          state_d  = ST_RUN;
          size_d   = burst_size;
          scale_d  = scale_factor;
          issued_d = '0;
          sent_d   = '0;
`ifdef DAC_BURST_UNDERRUN_EN
          under_d  = '0;
`endif
        end
      end
      ST_RUN: begin
        if (size_q != '0 && sent_d == size_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (halt) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!m_valid_d) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      size_q    <= '0;
      scale_q   <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      m_valid_q <= 1'b0;
      m_batch_q <= '0;
      done_q    <= 1'b0;
`ifdef DAC_BURST_UNDERRUN_EN
      under_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      scale_q   <= scale_d;
      issued_q  <= issued_d;
      sent_q    <= sent_d;
      m_valid_q <= m_valid_d;
      m_batch_q <= m_batch_d;
      done_q    <= done_d;
`ifdef DAC_BURST_UNDERRUN_EN
      under_q   <= under_d;
`endif
    end
  end

  assign m_valid    = m_valid_q;
  assign m_batch    = m_batch_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign sent_count = sent_q;
`ifdef DAC_BURST_UNDERRUN_EN
  assign underrun_count = under_q;
`endif

endmodule

// File: tb/tb_dac_burst_ctrl.sv
// Self-checking bench for dac_burst_ctrl: scaling vectors, random
// bursts against a queue model, halt/flush, reset and handshake cases.
module tb_dac_burst_ctrl;
  import daq_params_pkg::*;

  localparam int SW = daq_params_pkg::SAMPLE_WIDTH;
  localparam int BN = daq_params_pkg::BATCH_SIZE;
  localparam int BW = daq_params_pkg::BS_WIDTH;
  localparam int W  = SW * BN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic [BW-1:0] burst_size = '0;
  logic [3:0]    scale_factor = '0;
  logic [W-1:0]  s_batch = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_batch;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [BW-1:0] sent_count;
`ifdef DAC_BURST_UNDERRUN_EN
  logic [BW-1:0] underrun_count;
`endif

  dac_burst_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt         (halt),
    .burst_size   (burst_size),
    .scale_factor (scale_factor),
    .s_batch      (s_batch),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_batch      (m_batch),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done),
    .sent_count   (sent_count)
`ifdef DAC_BURST_UNDERRUN_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [W-1:0] act,
                       logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // floor division by 2^s on the signed sample value
  function automatic logic [W-1:0] ref_scale(logic [W-1:0] b, int s);
    logic [W-1:0] r;
    for (int i = 0; i < BN; i++) begin
      logic [SW-1:0] sm;
      int v;
      int d;
      int q;
      sm = b[i*SW +: SW];
      v = int'($signed(sm));
      d = 1 << s;
      q = (v >= 0) ? v / d : -((-v + d - 1) / d);
      r[i*SW +: SW] = q[SW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_batch();
    logic [W-1:0] r;
    for (int i = 0; i < BN; i++) begin
      logic [31:0] t;
      t = $urandom;
      r[i*SW +: SW] = t[SW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rep(logic [SW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < BN; i++) r[i*SW +: SW] = v;
    return r;
  endfunction

  // reference model: expected stream of scaled batches
  logic [W-1:0] exp_q[$];
  int           mdl_scale = 0;
  int           acc_cnt = 0;
  int           del_cnt = 0;
  int           und_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_batch = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_batch", m_batch, prev_batch);
      end
      if (m_valid && m_ready) begin
`ifdef DAC_BURST_UNDERRUN_EN
        if (m_batch == '0 &&
            (exp_q.size() == 0 || exp_q[0] != '0)) begin
          und_cnt++;
        end else
`endif
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL deliver_extra: got %0h want none", m_batch);
        end else begin
          check("deliver", m_batch, exp_q.pop_front());
        end
        del_cnt++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(ref_scale(s_batch, mdl_scale));
        acc_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_batch = m_batch;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // config inputs are scrambled after the start pulse
  task automatic start_burst(int size, int scale);
    logic [31:0] t;
    burst_size   = BW'(size);
    scale_factor = 4'(scale);
    mdl_scale    = scale;
    exp_q.delete();
    acc_cnt = 0;
    del_cnt = 0;
    und_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = $urandom;
    burst_size   = t[BW-1:0];
    scale_factor = t[19:16];
  endtask

  task automatic run_burst(string tag, int size, int scale, int vpct,
                           int rpct, bit toggle, bit fixed,
                           logic [SW-1:0] smp);
    int cyc;
    int nd;
    bit seen;
    cyc  = 0;
    nd   = 0;
    seen = 1'b0;
    start_burst(size, scale);
    while (!seen && cyc < 600) begin
      s_valid = ($urandom_range(99) < vpct);
      s_batch = fixed ? rep(smp) : rand_batch();
      m_ready = toggle ? (cyc % 2 == 0) : ($urandom_range(99) < rpct);
      tick();
      cyc++;
      if (done) seen = 1'b1;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check({tag, "_done"}, seen, 1'b1);
    check({tag, "_sent"}, sent_count, BW'(size));
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_acc"}, acc_cnt, size);
    check({tag, "_del"}, del_cnt, size);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [SW-1:0] smp;
    int            scale;
    logic [SW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{16'h1234, 0,  16'h1234};
    vecs[1] = '{16'h8000, 3,  16'hF000};
    vecs[2] = '{16'h7FFF, 3,  16'h0FFF};
    vecs[3] = '{16'h8000, 15, 16'hFFFF};
    vecs[4] = '{16'h7FFF, 15, 16'h0000};
    vecs[5] = '{16'hFFFF, 1,  16'hFFFF};
    vecs[6] = '{16'h4000, 2,  16'h1000};
    vecs[7] = '{16'hC001, 1,  16'hE000};

    // reset state
    #2;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_batch", m_batch, '0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sent", sent_count, '0);
    #21 rst_n = 1'b1;
    tick();

    // scaling table, single-batch bursts with done latency
    foreach (vecs[k]) begin
      s_batch = rep(vecs[k].smp);
      s_valid = 1'b1;
      m_ready = 1'b1;
      start_burst(1, vecs[k].scale);
      check("tbl_s_ready", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      check("tbl_m_valid", m_valid, 1'b1);
      check("tbl_m_batch", m_batch, rep(vecs[k].exp));
      tick();
      check("tbl_done", done, 1'b1);
      check("tbl_sent", sent_count, BW'(1));
      check("tbl_busy", busy, 1'b0);
      tick();
      check("tbl_done_low", done, 1'b0);
      m_ready = 1'b0;
    end

    // halt alone and halt+start while idle
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("idle_halt_busy", busy, 1'b0);
    check("idle_halt_done", done, 1'b0);
    halt  = 1'b1;
    start = 1'b1;
    tick();
    halt  = 1'b0;
    start = 1'b0;
    check("halt_start_busy", busy, 1'b0);
    tick();
    check("halt_start_done", done, 1'b0);

    run_burst("b4", 4, 0, 100, 100, 1'b0, 1'b1, 16'h1234);
    run_burst("tgl", 8, 0, 100, 0, 1'b1, 1'b0, '0);

    for (int r = 0; r < 6; r++) begin
`ifdef DAC_BURST_UNDERRUN_EN
      run_burst("rnd", $urandom_range(12, 1), $urandom_range(15),
                100, $urandom_range(100, 40), 1'b0, 1'b0, '0);
`else
      run_burst("rnd", $urandom_range(12, 1), $urandom_range(15),
                $urandom_range(100, 40), $urandom_range(100, 40),
                1'b0, 1'b0, '0);
`endif
    end

    // continuous burst halted with output stalled
    s_valid = 1'b1;
    m_ready = 1'b1;
    start_burst(0, 2);
    n = 0;
    while (acc_cnt < 10 && n < 50) begin
      s_batch = rand_batch();
      start = (n == 5);
      tick();
      start = 1'b0;
      n++;
    end
    check("halt_acc", acc_cnt, 10);
    m_ready = 1'b0;
    s_valid = 1'b0;
    halt  = 1'b1;
    start = 1'b1;
    scale_factor = 4'd7;
    tick();
    halt  = 1'b0;
    start = 1'b0;
    check("flush_busy", busy, 1'b1);
    check("flush_m_valid", m_valid, 1'b1);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_s_ready", s_ready, 1'b0);
      check("flush_no_done", done, 1'b0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("flush_done", done, 1'b1);
    check("flush_sent", sent_count, BW'(10));
    check("flush_idle", busy, 1'b0);
    check("flush_acc", acc_cnt, 10);
    check("flush_del", del_cnt, 10);
    tick();

    // reset in the middle of a burst
    s_valid = 1'b1;
    m_ready = 1'b1;
    start_burst(5, 1);
    n = 0;
    while (del_cnt < 2 && n < 50) begin
      s_batch = rand_batch();
      tick();
      n++;
    end
    check("mid_del", del_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_batch", m_batch, '0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sent", sent_count, '0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_done", done, 1'b0);
      tick();
    end
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_done", done, 1'b0);
    run_burst("rerun", 5, 1, 100, 100, 1'b0, 1'b0, '0);

`ifdef DAC_BURST_UNDERRUN_EN
    begin
      int gap;
      bit seen;
      gap  = 0;
      seen = 1'b0;
      m_ready = 1'b1;
      s_batch = rep(16'h1111);
      start_burst(6, 0);
      n = 0;
      while (!seen && n < 100) begin
        s_valid = !(acc_cnt == 2 && gap < 2);
        if (!s_valid) gap++;
        tick();
        n++;
        if (done) seen = 1'b1;
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
      check("und_done", seen, 1'b1);
      check("und_sent", sent_count, BW'(6));
      check("und_count", underrun_count, BW'(2));
      check("und_zero_seen", und_cnt, 2);
      check("und_acc", acc_cnt, 4);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
